fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
- Instruction-fetch front end of the pipelined OTTER core. It is the consumer of the next-PC selection, not a producer of it.
- Owns the PC register and turns execute-stage redirects (JALR/BRANCH/JAL, same 2-bit select encoding as the PC mux) into the next PC.
- Fetches from instruction memory over a single-outstanding req/gnt/rvalid handshake.
- Presents {IF_INSTR, IF_PC, IF_VALID} to the decode stage; honours STALL and flushes on redirect.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, IF_INSTR value when the output slot is empty or flushed.

Ports:
- CLK  in  1  core clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- STALL  in  1  decode stage cannot accept; hold IF_* outputs.
- REDIRECT_VALID  in  1  execute stage resolves a control transfer this cycle.
- REDIRECT_SEL  in  2  00 none, 01 JALR, 10 BRANCH, 11 JAL.
- JALR  in  32  JALR target.
- BRANCH  in  32  branch target.
- JAL  in  32  JAL target.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  32  fetch address.
- IMEM_GNT  in  1  request accepted this cycle.
- IMEM_RVALID  in  1  response data valid.
- IMEM_RDATA  in  32  fetched instruction.
- IF_VALID  out  1  IF_INSTR/IF_PC hold a valid instruction.
- IF_INSTR  out  32  instruction to decode.
- IF_PC  out  32  address of IF_INSTR.
- FLUSH  out  1  one-cycle pulse, downstream must squash.
- MISALIGN  out  1  sticky misaligned-target error.

Behaviour:
- Reset (async, RST_N=0):
  - PC=RESET_VEC, state IDLE.
  - IMEM_REQ=0, IMEM_ADDR=RESET_VEC.
  - IF_VALID=0, IF_INSTR=NOP_INSTR, IF_PC=0.
  - FLUSH=0, MISALIGN=0, skid buffer empty.
  - Reset mid-transaction abandons any outstanding response silently.
- States: IDLE, REQ, WAIT, HOLD, DROP, HALT.
  - IDLE: exits to REQ on the first edge after reset release.
  - REQ: IMEM_REQ=1, IMEM_ADDR=PC. On IMEM_GNT go to WAIT and record the request address.
  - WAIT: on IMEM_RVALID:
    - If the output slot is free (IF_VALID=0 or STALL=0): load IF_INSTR=RDATA, IF_PC=recorded address, IF_VALID=1; PC<=PC+4; go to REQ.
    - Else: store RDATA/address in the 1-entry skid buffer; PC<=PC+4; go to HOLD.
  - HOLD: no requests issued. When STALL=0, the skid buffer moves to the IF_* outputs; go to REQ.
  - DROP: an outstanding response belongs to a squashed path. Discard the next RVALID with no output change, then go to REQ at the redirected PC.
  - HALT: IMEM_REQ=0, IF_VALID=0. Left only by reset.
- Decode consumption: with STALL=0, IF_VALID deasserts the cycle after consumption unless new data loads the slot that same edge.
- Throughput with a zero-wait memory (GNT in the REQ cycle, RVALID the next cycle): one instruction per 2 cycles. First IMEM_REQ asserts 1 cycle after reset release.
- Redirect (REDIRECT_VALID=1 with SEL!=00, any state except HALT):
  - Target is the selected input. JALR target has bit 0 cleared.
  - Target[1:0]!=0: MISALIGN<=1 (sticky), FLUSH pulses, go to HALT.
  - Otherwise, next edge: PC<=target, IF_VALID<=0, IF_INSTR<=NOP_INSTR, skid buffer cleared, FLUSH=1 for exactly one cycle.
  - Next state:
    - DROP if in WAIT without RVALID that cycle, or in REQ with GNT that cycle.
    - REQ in every other case. In REQ without GNT the request is withdrawn and re-issued with the new address; the memory protocol permits this.
  - Redirect overrides STALL. A response arriving in the same cycle as a redirect is discarded.
- REDIRECT_VALID=1 with SEL=00 is ignored, equivalent to no redirect.
- IMEM_ADDR is stable while IMEM_REQ=1 and IMEM_GNT=0, except on redirect.
- PC+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.

Test Plan:
- Reset release, memory returns 32'h00500093 at 0 and 32'h00A00113 at 4 (zero-wait) -> IMEM_ADDR 0 then 4; IF_PC=0/IF_INSTR=32'h00500093, then IF_PC=4/IF_INSTR=32'h00A00113; IF_VALID pulses every 2nd cycle.
- STALL=1 while IF_VALID=1 and the next RVALID arrives -> IF_* unchanged, no new IMEM_REQ. Release STALL -> skid data appears next cycle, fetch resumes at PC+4.
- REDIRECT_SEL=11, JAL=32'h0000_0100 while in WAIT -> FLUSH high one cycle, IF_VALID=0, the in-flight response is dropped, next IMEM_ADDR=32'h100.
- REDIRECT_SEL=01, JALR=32'h0000_0203 -> bit 0 cleared gives 32'h202, misaligned -> MISALIGN=1 and stays set; IMEM_REQ=0 until RST_N asserts.
- Redirect to 32'h40 in REQ with no GNT for 3 cycles -> IMEM_ADDR changes to 32'h40 next cycle and stays stable until GNT.
- RST_N asserted in WAIT, late RVALID after release -> ignored, first fetch at RESET_VEC, IF_VALID=0 until that response arrives.

Source files
------------

// File: rtl/fetch_redirect_unit_if.sv
// Instruction-memory fetch bus: single outstanding req/gnt/rvalid.
// master = fetch unit, slave = instruction memory.
interface fetch_redirect_unit_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_GNT,
    input  IMEM_RVALID,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_GNT,
    output IMEM_RVALID,
    output IMEM_RDATA
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// OTTER fetch front end: PC register, redirect handling, imem fetch
// with a one-entry skid buffer toward decode.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        REDIRECT_VALID,
  input  logic [1:0]  REDIRECT_SEL,
  input  logic [31:0] JALR,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JAL,
  fetch_redirect_unit_if.master imem,
  output logic        IF_VALID,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  output logic        FLUSH,
  output logic        MISALIGN
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP,
    HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] raddr_q, raddr_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_i_q, skid_i_d;
  logic [31:0] skid_p_q, skid_p_d;
  logic        ifv_q, ifv_d;
  logic [31:0] ifi_q, ifi_d;
  logic [31:0] ifp_q, ifp_d;
  logic        flush_q, flush_d;
  logic        mis_q, mis_d;

  logic        gnt;
  logic        rvalid;
  logic        redir;
  logic        slot_free;
  logic        in_flight;
  logic [31:0] tgt;

  assign gnt    = imem.IMEM_GNT;
  assign rvalid = imem.IMEM_RVALID;

  assign redir = REDIRECT_VALID
               && (REDIRECT_SEL != 2'b00)
               && (state_q != HALT);

  assign slot_free = !ifv_q || !STALL;

  // A response is still owed if we were waiting and it has not arrived,
  // or the request was just granted.
  assign in_flight =
      ((state_q == WAIT || state_q == DROP) && !rvalid)
      || (state_q == REQ && gnt);

  always_comb begin
    tgt = 32'h0;
    unique case (REDIRECT_SEL)
      2'b01:   tgt = JALR & ~32'h1;
      2'b10:   tgt = BRANCH;
      2'b11:   tgt = JAL;
      default: tgt = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    raddr_d  = raddr_q;
    skid_v_d = skid_v_q;
    skid_i_d = skid_i_q;
    skid_p_d = skid_p_q;
    ifv_d    = ifv_q;
    ifi_d    = ifi_q;
    ifp_d    = ifp_q;
    flush_d  = 1'b0;
    mis_d    = mis_q;

    if (ifv_q && !STALL) ifv_d = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (gnt) begin
          raddr_d = pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (rvalid) begin
          pc_d = pc_q + 32'd4;
          if (slot_free) begin
            ifv_d   = 1'b1;
            ifi_d   = imem.IMEM_RDATA;
            ifp_d   = raddr_q;
            state_d = REQ;
          end else begin
            skid_v_d = 1'b1;
            skid_i_d = imem.IMEM_RDATA;
            skid_p_d = raddr_q;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (!STALL) begin
          ifv_d    = 1'b1;
          ifi_d    = skid_i_q;
          ifp_d    = skid_p_q;
          skid_v_d = 1'b0;
          state_d  = REQ;
        end
      end
      DROP: begin
        if (rvalid) state_d = REQ;
      end
      HALT: ifv_d = 1'b0;
      default: state_d = IDLE;
    endcase

    // Redirect wins over stall and over any same-cycle response.
    if (redir) begin
      ifv_d    = 1'b0;
      ifi_d    = NOP_INSTR;
      skid_v_d = 1'b0;
      flush_d  = 1'b1;
      if (tgt[1:0] != 2'b00) begin
        mis_d   = 1'b1;
        state_d = HALT;
      end else begin
        pc_d    = tgt;
        state_d = in_flight ? DROP : REQ;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      pc_q     <= RESET_VEC;
      raddr_q  <= RESET_VEC;
      skid_v_q <= 1'b0;
      skid_i_q <= NOP_INSTR;
      skid_p_q <= 32'h0;
      ifv_q    <= 1'b0;
      ifi_q    <= NOP_INSTR;
      ifp_q    <= 32'h0;
      flush_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      raddr_q  <= raddr_d;
      skid_v_q <= skid_v_d;
      skid_i_q <= skid_i_d;
      skid_p_q <= skid_p_d;
      ifv_q    <= ifv_d;
      ifi_q    <= ifi_d;
      ifp_q    <= ifp_d;
      flush_q  <= flush_d;
      mis_q    <= mis_d;
    end
  end

  assign imem.IMEM_REQ  = (state_q == REQ);
  assign imem.IMEM_ADDR = pc_q;
  assign IF_VALID       = ifv_q;
  assign IF_INSTR       = ifi_q;
  assign IF_PC          = ifp_q;
  assign FLUSH          = flush_q;
  assign MISALIGN       = mis_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed scenarios plus random
// stimulus against a transaction-level model and a latency-queue imem.
module tb_fetch_redirect_unit;
  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        STALL = 1'b0;
  logic        REDIRECT_VALID = 1'b0;
  logic [1:0]  REDIRECT_SEL = 2'b00;
  logic [31:0] JALR = 32'h0;
  logic [31:0] BRANCH = 32'h0;
  logic [31:0] JAL = 32'h0;
  logic        IF_VALID;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC;
  logic        FLUSH;
  logic        MISALIGN;

  fetch_redirect_unit_if bus();

  fetch_redirect_unit #(.RESET_VEC(RV), .NOP_INSTR(NOP)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .STALL(STALL),
    .REDIRECT_VALID(REDIRECT_VALID),
    .REDIRECT_SEL(REDIRECT_SEL),
    .JALR(JALR),
    .BRANCH(BRANCH),
    .JAL(JAL),
    .imem(bus.master),
    .IF_VALID(IF_VALID),
    .IF_INSTR(IF_INSTR),
    .IF_PC(IF_PC),
    .FLUSH(FLUSH),
    .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: fetch is "started" after reset, may have one
  // response owed (possibly to be dropped), a skid queue, and a halt flag.
  logic [31:0] m_pc, m_raddr, m_ii, m_ip;
  bit          m_started, m_halt, m_out, m_drop;
  bit          m_iv, m_flush, m_mis;
  logic [31:0] sk_i[$];
  logic [31:0] sk_p[$];

  function automatic bit m_req();
    return m_started && !m_halt && !m_out && (sk_i.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc = RV; m_raddr = RV; m_ii = NOP; m_ip = 32'h0;
    m_started = 0; m_halt = 0; m_out = 0; m_drop = 0;
    m_iv = 0; m_flush = 0; m_mis = 0;
    sk_i.delete(); sk_p.delete();
  endtask

  task automatic model_step(bit g, bit v, logic [31:0] d);
    bit          iv_old, req;
    logic [31:0] tgt;
    iv_old = m_iv;
    req = m_req();
    m_flush = 0;
    if (REDIRECT_VALID && REDIRECT_SEL != 2'b00 && !m_halt) begin
      case (REDIRECT_SEL)
        2'b01:   tgt = JALR & 32'hFFFF_FFFE;
        2'b10:   tgt = BRANCH;
        default: tgt = JAL;
      endcase
      m_iv = 0; m_ii = NOP; m_flush = 1; m_started = 1;
      sk_i.delete(); sk_p.delete();
      if (tgt[1:0] != 2'b00) begin
        m_mis = 1; m_halt = 1;
      end else begin
        m_pc = tgt;
        m_drop = (m_out && !v) || (req && g);
        m_out = m_drop;
      end
      return;
    end
    if (m_halt) return;
    if (!m_started) begin
      m_started = 1;
      return;
    end
    if (m_iv && !STALL) m_iv = 0;
    if (req && g) begin
      m_out = 1; m_drop = 0; m_raddr = m_pc;
    end else if (m_out && v) begin
      m_out = 0;
      if (!m_drop) begin
        m_pc = m_pc + 32'd4;
        if (!iv_old || !STALL) begin
          m_iv = 1; m_ii = d; m_ip = m_raddr;
        end else begin
          sk_i.push_back(d); sk_p.push_back(m_raddr);
        end
      end
      m_drop = 0;
    end else if (sk_i.size() != 0 && !STALL) begin
      m_iv = 1; m_ii = sk_i.pop_front(); m_ip = sk_p.pop_front();
    end
  endtask

  // Instruction memory: grants with some probability, answers in order
  // after a random latency; its queue survives reset (late responses).
  int unsigned cyc = 0;
  logic [31:0] mq_a[$];
  int unsigned mq_due[$];
  int          gnt_pct = 100;
  int          lat_max = 0;
  bit          gnt_block = 0;
  bit          rv_block = 0;

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic compare();
    bit r;
    r = m_req();
    chk("imem_req", {31'h0, bus.IMEM_REQ}, {31'h0, r});
    if (r) chk("imem_addr", bus.IMEM_ADDR, m_pc);
    chk("if_valid", {31'h0, IF_VALID}, {31'h0, m_iv});
    if (m_iv) begin
      chk("if_instr", IF_INSTR, m_ii);
      chk("if_pc", IF_PC, m_ip);
    end
    chk("flush", {31'h0, FLUSH}, {31'h0, m_flush});
    chk("misalign", {31'h0, MISALIGN}, {31'h0, m_mis});
  endtask

  task automatic cycle();
    bit          g, v;
    logic [31:0] d, a;
    g = m_req() && !gnt_block && ($urandom_range(99) < gnt_pct);
    v = (mq_a.size() != 0) && (mq_due[0] <= cyc) && !rv_block;
    d = v ? mem_fn(mq_a[0]) : $urandom;
    a = m_pc;
    bus.IMEM_GNT = g;
    bus.IMEM_RVALID = v;
    bus.IMEM_RDATA = d;
    model_step(g, v, d);
    if (v) begin
      void'(mq_a.pop_front());
      void'(mq_due.pop_front());
    end
    if (g) begin
      mq_a.push_back(a);
      mq_due.push_back(cyc + 1 + $urandom_range(lat_max));
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    compare();
  endtask

  task automatic do_reset(int n);
    RST_N = 1'b0;
    STALL = 1'b0;
    REDIRECT_VALID = 1'b0;
    bus.IMEM_GNT = 1'b0;
    bus.IMEM_RVALID = 1'b0;
    bus.IMEM_RDATA = 32'h0;
    model_reset();
    #1;
    compare();
    chk("rst_addr", bus.IMEM_ADDR, RV);
    chk("rst_instr", IF_INSTR, NOP);
    chk("rst_pc", IF_PC, 32'h0);
    repeat (n) begin
      @(negedge CLK);
      cyc++;
    end
    RST_N = 1'b1;
    compare();
  endtask

  task automatic redirect(logic [1:0] sel, logic [31:0] t);
    REDIRECT_VALID = 1'b1;
    REDIRECT_SEL = sel;
    JALR = t; BRANCH = t; JAL = t;
  endtask

  task automatic no_redirect();
    REDIRECT_VALID = 1'b0;
    REDIRECT_SEL = 2'b00;
  endtask

  initial begin
    logic [31:0] b;
    bus.IMEM_GNT = 1'b0;
    bus.IMEM_RVALID = 1'b0;
    bus.IMEM_RDATA = 32'h0;
    @(negedge CLK);
    do_reset(2);

    // Zero-wait streaming
    cycle();
    chk("t1_req0", {31'h0, bus.IMEM_REQ}, 32'h1);
    chk("t1_addr0", bus.IMEM_ADDR, 32'h0);
    cycle();
    chk("t1_wait", {31'h0, bus.IMEM_REQ}, 32'h0);
    cycle();
    chk("t1_v0", {31'h0, IF_VALID}, 32'h1);
    chk("t1_pc0", IF_PC, 32'h0);
    chk("t1_i0", IF_INSTR, 32'h0050_0093);
    chk("t1_addr4", bus.IMEM_ADDR, 32'h4);
    cycle();
    chk("t1_gap", {31'h0, IF_VALID}, 32'h0);
    cycle();
    chk("t1_pc4", IF_PC, 32'h4);
    chk("t1_i4", IF_INSTR, 32'h00A0_0113);

    // Stall into skid buffer
    STALL = 1'b1;
    cycle();
    cycle();
    chk("t2_hold_pc", IF_PC, 32'h4);
    chk("t2_hold_req", {31'h0, bus.IMEM_REQ}, 32'h0);
    cycle();
    chk("t2_hold_req2", {31'h0, bus.IMEM_REQ}, 32'h0);
    STALL = 1'b0;
    cycle();
    chk("t2_skid_pc", IF_PC, 32'h8);
    chk("t2_skid_v", {31'h0, IF_VALID}, 32'h1);
    chk("t2_addr12", bus.IMEM_ADDR, 32'hC);

    // JAL while waiting: in-flight response dropped
    cycle();
    rv_block = 1;
    redirect(2'b11, 32'h100);
    cycle();
    no_redirect();
    rv_block = 0;
    chk("t3_flush", {31'h0, FLUSH}, 32'h1);
    chk("t3_v", {31'h0, IF_VALID}, 32'h0);
    chk("t3_nop", IF_INSTR, NOP);
    cycle();
    chk("t3_flush_end", {31'h0, FLUSH}, 32'h0);
    chk("t3_addr", bus.IMEM_ADDR, 32'h100);
    chk("t3_req", {31'h0, bus.IMEM_REQ}, 32'h1);

    // Redirect while requesting without grant
    gnt_block = 1;
    redirect(2'b10, 32'h40);
    cycle();
    no_redirect();
    for (int i = 0; i < 3; i++) begin
      chk("t5_addr", bus.IMEM_ADDR, 32'h40);
      cycle();
    end
    chk("t5_addr_last", bus.IMEM_ADDR, 32'h40);
    gnt_block = 0;
    cycle();

    // Misaligned JALR halts until reset
    redirect(2'b01, 32'h203);
    cycle();
    no_redirect();
    chk("t4_mis", {31'h0, MISALIGN}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t4_sticky", {31'h0, MISALIGN}, 32'h1);
      chk("t4_noreq", {31'h0, bus.IMEM_REQ}, 32'h0);
    end
    redirect(2'b11, 32'h80);
    cycle();
    no_redirect();
    chk("t4_halt_noflush", {31'h0, FLUSH}, 32'h0);

    // Reset while waiting; late response must be ignored
    do_reset(2);
    cycle();
    cycle();
    do_reset(2);
    cycle();
    chk("t6_addr", bus.IMEM_ADDR, RV);
    chk("t6_v", {31'h0, IF_VALID}, 32'h0);
    cycle();
    chk("t6_v2", {31'h0, IF_VALID}, 32'h0);
    cycle();
    chk("t6_pc", IF_PC, 32'h0);
    chk("t6_i", IF_INSTR, 32'h0050_0093);

    // PC wrap
    gnt_block = 1;
    redirect(2'b11, 32'hFFFF_FFFC);
    cycle();
    no_redirect();
    gnt_block = 0;
    cycle();
    cycle();
    chk("wrap_pc", IF_PC, 32'hFFFF_FFFC);
    chk("wrap_addr", bus.IMEM_ADDR, 32'h0);

    // Random phase
    gnt_pct = 70;
    lat_max = 2;
    for (int i = 0; i < 4000; i++) begin
      STALL = ($urandom_range(3) == 0);
      REDIRECT_VALID = ($urandom_range(9) == 0);
      REDIRECT_SEL = 2'($urandom_range(3));
      b = $urandom & 32'hFFFF_FFFC;
      JAL = b | (($urandom_range(59) == 0) ? 32'h2 : 32'h0);
      b = $urandom & 32'hFFFF_FFFC;
      BRANCH = b | (($urandom_range(59) == 0) ? 32'h1 : 32'h0);
      b = $urandom & 32'hFFFF_FFFC;
      JALR = b | 32'($urandom_range(1))
           | (($urandom_range(59) == 0) ? 32'h2 : 32'h0);
      if ($urandom_range(249) == 0) do_reset(2);
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
